lut_mem_stage: RTL and testbench
================================

Name: lut_mem_stage

Overview:
- Memory-access stage of the processor datapath, directly upstream of the address LUT and downstream of decode.
- Takes a 5-bit LUT index, a byte offset and a load/store command from decode.
- Drives the LUT address, registers the returned 8-bit base address, adds the offset and performs one access to the synchronous data memory.
- Returns load data and a one-cycle done pulse; holds busy so fetch stalls for the duration.

Parameters:
- VALID_MASK, 32'h801F_FFFF, bit i set means LUT entry i is populated (entries 0..20 and 31); an unset index raises fault.
- DW, 8, data and address width of the data memory.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse, sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; latched with start
- lut_idx  in  5  LUT index; latched with start
- offset  in  DW  byte offset added to LUT base; latched with start
- store_data  in  DW  store payload; latched with start
- lut_addr  out  5  address to the LUT (combinational lookup)
- lut_data  in  DW  base address returned by the LUT
- dm_addr  out  DW  data memory address
- dm_wen  out  1  data memory write enable
- dm_wdata  out  DW  data memory write data
- dm_rdata  in  DW  data memory read data, valid one cycle after the address is presented
- load_data  out  DW  last load result
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  set with done when the index is unmapped

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; idx_q, addr_q, off_q, wd_q, load_data = 0.
  - busy, done, fault, dm_wen = 0; lut_addr = 0; dm_addr = 0.
  - Reset mid-operation aborts the access, and dm_wen drops immediately.
- States are IDLE, LOOKUP, ACCESS, RDWAIT, DONE.
- IDLE: on start=1, latch lut_idx, offset, store_data and is_store; go to LOOKUP.
- LOOKUP:
  - lut_addr = idx_q.
  - If VALID_MASK[idx_q] = 0: go to DONE with fault pending; no memory access occurs.
  - Otherwise: addr_q <= lut_data + off_q (modulo 2^DW, carry discarded); go to ACCESS.
- ACCESS: dm_addr = addr_q.
  - Store: dm_wen = 1 and dm_wdata = wd_q for exactly this cycle; go to DONE.
  - Load: dm_wen = 0; go to RDWAIT.
- RDWAIT: load_data <= dm_rdata at the closing edge; go to DONE.
- DONE:
  - done = 1 for one cycle; fault = 1 only for an unmapped index, otherwise 0.
  - Go to IDLE.
  - A start in the same cycle is ignored; a new request is accepted the cycle after DONE.
- Latency, counting the start edge as cycle 0 and giving the cycle done is high:
  - store = 3
  - load = 4
  - fault = 2
- Throughput: one request per 4 cycles (store) or 5 cycles (load).
- start while busy: ignored, with no effect on latched fields.
- load_data holds its value until the next successful load; stores and faults leave it unchanged.
- lut_addr holds idx_q outside LOOKUP; dm_addr holds addr_q outside ACCESS.
- dm_wdata = wd_q at all times; only dm_wen qualifies a write.

Test Plan:
- Reset with rst_n=0 mid-ACCESS of a store → dm_wen, busy, done go 0 asynchronously, state IDLE, no write recorded by the memory model.
- Load, idx=3 (LUT 63), offset=2, memory[65]=0xA5 → dm_addr=65 in cycle 2, done and load_data=0xA5 in cycle 4, fault=0.
- Store, idx=31 (LUT 32), offset=0xF0, data=0x3C → dm_addr=16 (wrap), dm_wen high exactly one cycle, done in cycle 3, memory[16]=0x3C.
- Load, idx=25 (unmapped) → done=1, fault=1 in cycle 2; dm_wen never asserted; load_data unchanged.
- start re-pulsed every cycle during a load with idx=0, offset=0 → only the first is served, latched fields unchanged, next request accepted in the cycle after done.
- Back-to-back store then load of idx=10 (LUT 70), offset=0 → load returns the value just stored at address 70.

Source files
------------

// File: rtl/lut_mem_stage_if.sv
// rtl/lut_mem_stage_if.sv - decode-side request/response handshake of the LUT memory stage
interface lut_mem_stage_if #(
    parameter int DW = 8
);
    logic          start;
    logic          is_store;
    logic [4:0]    lut_idx;
    logic [DW-1:0] offset;
    logic [DW-1:0] store_data;
    logic [DW-1:0] load_data;
    logic          busy;
    logic          done;
    logic          fault;

    modport master (
        output start, is_store, lut_idx, offset, store_data,
        input  load_data, busy, done, fault
    );

    modport slave (
        input  start, is_store, lut_idx, offset, store_data,
        output load_data, busy, done, fault
    );
endinterface

// File: rtl/lut_mem_stage.sv
// rtl/lut_mem_stage.sv - LUT base lookup plus offset, then one synchronous data memory access
module lut_mem_stage #(
    parameter logic [31:0] VALID_MASK = 32'h801F_FFFF,
    parameter int          DW         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    lut_mem_stage_if.slave      req,
    output logic [4:0]          lut_addr,
    input  logic [DW-1:0]       lut_data,
    output logic [DW-1:0]       dm_addr,
    output logic                dm_wen,
    output logic [DW-1:0]       dm_wdata,
    input  logic [DW-1:0]       dm_rdata
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ACCESS,
        S_RDWAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] off_q, off_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] ld_q, ld_d;
    logic          st_q, st_d;
    logic          flt_q, flt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            wd_q    <= '0;
            ld_q    <= '0;
            st_q    <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            wd_q    <= wd_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            flt_q   <= flt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        off_d   = off_q;
        wd_d    = wd_q;
        ld_d    = ld_q;
        st_d    = st_q;
        flt_d   = flt_q;
        case (state_q)
            S_IDLE: begin
                if (req.start) begin
                    idx_d   = req.lut_idx;
                    off_d   = req.offset;
                    wd_d    = req.store_data;
                    st_d    = req.is_store;
                    flt_d   = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // Unpopulated entries skip the memory entirely and report through fault.
                if (!VALID_MASK[idx_q]) begin
                    flt_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = lut_data + off_q;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = st_q ? S_DONE : S_RDWAIT;
            S_RDWAIT: begin
                ld_d    = dm_rdata;
                state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Decoded straight from state so an asynchronous reset kills the write strobe at once.
    assign lut_addr      = idx_q;
    assign dm_addr       = addr_q;
    assign dm_wdata      = wd_q;
    assign dm_wen        = (state_q == S_ACCESS) && st_q;
    assign req.busy      = (state_q != S_IDLE);
    assign req.done      = (state_q == S_DONE);
    assign req.fault     = (state_q == S_DONE) && flt_q;
    assign req.load_data = ld_q;
endmodule

// File: tb/tb_lut_mem_stage.sv
// tb/tb_lut_mem_stage.sv - directed bench for lut_mem_stage with LUT and data memory models
module tb_lut_mem_stage;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    lut_addr;
    logic [DW-1:0] lut_data;
    logic [DW-1:0] dm_addr;
    logic          dm_wen;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;

    logic [DW-1:0] mem [256];
    logic          pl_en;
    logic [DW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_mem_stage_if #(.DW(DW)) req_if ();

    lut_mem_stage #(.VALID_MASK(32'h801F_FFFF), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_if.slave),
        .lut_addr (lut_addr),
        .lut_data (lut_data),
        .dm_addr  (dm_addr),
        .dm_wen   (dm_wen),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata)
    );

    function automatic logic [7:0] lut_model(input logic [4:0] a);
        case (a)
            5'd0:    return 8'h50;
            5'd3:    return 8'd63;
            5'd10:   return 8'd70;
            5'd31:   return 8'd32;
            default: return {a, 3'b001};
        endcase
    endfunction

    assign lut_data = lut_model(lut_addr);

    always @(posedge clk) begin
        if (pl_en)       mem[pl_addr] <= pl_data;
        else if (dm_wen) mem[dm_addr] <= dm_wdata;
        dm_rdata <= mem[dm_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Cycle 0 is the cycle start is presented; outputs are sampled at each later negedge.
    task automatic run_req(input logic st, input logic [4:0] idx, input logic [7:0] off,
                           input logic [7:0] wd, input logic hold,
                           output int done_cyc, output logic flt, output int wen_cnt,
                           output logic [7:0] wen_addr, output logic [7:0] addr_c2,
                           output logic [4:0] la_c1);
        @(negedge clk);
        req_if.start      = 1'b1;
        req_if.is_store   = st;
        req_if.lut_idx    = idx;
        req_if.offset     = off;
        req_if.store_data = wd;
        done_cyc = -1;
        flt      = 1'bx;
        wen_cnt  = 0;
        wen_addr = 8'h00;
        addr_c2  = 8'h00;
        la_c1    = 5'h00;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (hold) begin
                req_if.start      = 1'b1;
                req_if.is_store   = 1'b1;
                req_if.lut_idx    = 5'd25;
                req_if.offset     = 8'hFF;
                req_if.store_data = 8'hEE;
            end else begin
                req_if.start = 1'b0;
            end
            if (c == 1) la_c1 = lut_addr;
            if (c == 2) addr_c2 = dm_addr;
            if (dm_wen) begin
                wen_cnt++;
                wen_addr = dm_addr;
            end
            if (req_if.done) begin
                done_cyc = c;
                flt      = req_if.fault;
                break;
            end
        end
    endtask

    int         dc;
    logic       fl;
    int         wc;
    logic [7:0] wa;
    logic [7:0] a2;
    logic [4:0] l1;

    initial begin
        rst_n             = 1'b0;
        pl_en             = 1'b0;
        pl_addr           = '0;
        pl_data           = '0;
        req_if.start      = 1'b0;
        req_if.is_store   = 1'b0;
        req_if.lut_idx    = '0;
        req_if.offset     = '0;
        req_if.store_data = '0;
        repeat (2) @(negedge clk);

        check("rst_busy", req_if.busy, 0);
        check("rst_done", req_if.done, 0);
        check("rst_fault", req_if.fault, 0);
        check("rst_wen", dm_wen, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_load_data", req_if.load_data, 0);

        preload(8'd65, 8'hA5);
        preload(8'h50, 8'h5A);
        preload(8'd75, 8'h00);
        preload(8'd16, 8'h00);
        rst_n = 1'b1;

        run_req(1'b0, 5'd3, 8'd2, 8'h00, 1'b0, dc, fl, wc, wa, a2, l1);
        check("ld3_lut_addr_c1", l1, 3);
        check("ld3_dm_addr_c2", a2, 65);
        check("ld3_done_cycle", dc, 4);
        check("ld3_fault", fl, 0);
        check("ld3_no_write", wc, 0);
        check("ld3_load_data", req_if.load_data, 8'hA5);

        run_req(1'b1, 5'd31, 8'hF0, 8'h3C, 1'b0, dc, fl, wc, wa, a2, l1);
        check("st31_dm_addr_c2", a2, 16);
        check("st31_done_cycle", dc, 3);
        check("st31_fault", fl, 0);
        check("st31_wen_count", wc, 1);
        check("st31_wen_addr", wa, 16);
        check("st31_mem16", mem[16], 8'h3C);
        check("st31_load_data_kept", req_if.load_data, 8'hA5);

        run_req(1'b0, 5'd25, 8'd0, 8'h00, 1'b0, dc, fl, wc, wa, a2, l1);
        check("flt25_done_cycle", dc, 2);
        check("flt25_fault", fl, 1);
        check("flt25_no_write", wc, 0);
        check("flt25_load_data_kept", req_if.load_data, 8'hA5);

        run_req(1'b0, 5'd0, 8'd0, 8'h00, 1'b1, dc, fl, wc, wa, a2, l1);
        check("rep_lut_addr_c1", l1, 0);
        check("rep_dm_addr_c2", a2, 8'h50);
        check("rep_done_cycle", dc, 4);
        check("rep_fault", fl, 0);
        check("rep_no_write", wc, 0);
        check("rep_load_data", req_if.load_data, 8'h5A);

        run_req(1'b0, 5'd3, 8'd2, 8'h00, 1'b0, dc, fl, wc, wa, a2, l1);
        check("rep_next_done_cycle", dc, 4);
        check("rep_next_load_data", req_if.load_data, 8'hA5);

        run_req(1'b1, 5'd10, 8'd0, 8'hC3, 1'b0, dc, fl, wc, wa, a2, l1);
        check("b2b_st_done_cycle", dc, 3);
        check("b2b_st_wen_addr", wa, 70);
        run_req(1'b0, 5'd10, 8'd0, 8'h00, 1'b0, dc, fl, wc, wa, a2, l1);
        check("b2b_ld_done_cycle", dc, 4);
        check("b2b_ld_load_data", req_if.load_data, 8'hC3);

        @(negedge clk);
        req_if.start      = 1'b1;
        req_if.is_store   = 1'b1;
        req_if.lut_idx    = 5'd10;
        req_if.offset     = 8'd5;
        req_if.store_data = 8'h99;
        @(negedge clk);
        req_if.start = 1'b0;
        @(negedge clk);
        check("abort_wen_before", dm_wen, 1);
        check("abort_addr_before", dm_addr, 75);
        #1 rst_n = 1'b0;
        #1;
        check("abort_wen", dm_wen, 0);
        check("abort_busy", req_if.busy, 0);
        check("abort_done", req_if.done, 0);
        check("abort_dm_addr", dm_addr, 0);
        check("abort_load_data", req_if.load_data, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_mem75", mem[75], 8'h00);
        check("abort_busy_after", req_if.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
